// File: rtl/shift_add_multiplier.sv
// Sequential shift-and-add multiplier, one add/shift step per clock, unsigned or two's-complement.
// state | meaning
// IDLE  | ready, AQ holds last product
// BUSY  | WIDTH add/shift steps, then one settle cycle
// DONE  | one-cycle done pulse, product valid on AQ
module shift_add_multiplier #(
  parameter int WIDTH = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     M,
  input  logic [WIDTH-1:0]     Qin,
  output logic [2*WIDTH-1:0]   AQ,
  output logic                 ready,
  output logic                 done
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] m_reg;
  logic             mode_reg;
  logic [CW-1:0]    cnt;
  logic             step_en;
  logic             last_step;
  logic [WIDTH:0]   a_ext;
  logic [WIDTH:0]   m_ext;
  logic [WIDTH:0]   sum;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = BUSY;
      BUSY:    if (cnt == CW'(WIDTH)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ready = (state == IDLE);
    done  = (state == DONE);
  end

  assign step_en   = (state == BUSY) && (cnt != CW'(WIDTH));
  assign last_step = (cnt == CW'(WIDTH - 1));
  // Bit WIDTH is the carry in unsigned mode and the sign extension in signed mode.
  assign a_ext     = {mode_reg & AQ[2*WIDTH-1], AQ[2*WIDTH-1:WIDTH]};
  assign m_ext     = {mode_reg & m_reg[WIDTH-1], m_reg};

  always_comb begin
    sum = a_ext;
    if (AQ[0]) begin
      // The multiplier's sign bit carries negative weight, hence subtract on the last step.
      if (mode_reg && last_step) sum = a_ext - m_ext;
      else                       sum = a_ext + m_ext;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      AQ       <= '0;
      cnt      <= '0;
      m_reg    <= '0;
      mode_reg <= 1'b0;
    end else if (state == IDLE && start) begin
      AQ       <= {{WIDTH{1'b0}}, Qin};
      cnt      <= '0;
      m_reg    <= M;
      mode_reg <= signed_mode;
    end else if (step_en) begin
      AQ  <= {sum, AQ[WIDTH-1:1]};
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Bench for shift_add_multiplier at WIDTH 4, 8 and 16 against a cycle-count/arithmetic model.
module tb_shift_add_multiplier;

  localparam int WD [3] = '{4, 8, 16};

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  st   = '0;
  logic [2:0]  sm   = '0;
  logic [31:0] mv [3];
  logic [31:0] qv [3];
  logic [7:0]  aq4;
  logic [15:0] aq8;
  logic [31:0] aq16;
  logic [2:0]  rdy;
  logic [2:0]  dn;
  logic [31:0] aq_a [3];

  int n_vec = 0;
  int n_err = 0;

  // Model: per instance, idle flag, cycles since accept, expected product, AQ-valid flag.
  bit   [2:0]  idle_m  = 3'b111;
  bit   [2:0]  valid_m = 3'b111;
  int          cnt_m [3] = '{0, 0, 0};
  logic [31:0] exp_m [3] = '{32'd0, 32'd0, 32'd0};

  always #5 clock = ~clock;

  shift_add_multiplier #(.WIDTH(4)) u4 (
    .clock(clock), .reset(reset), .start(st[0]), .signed_mode(sm[0]),
    .M(mv[0][3:0]), .Qin(qv[0][3:0]), .AQ(aq4), .ready(rdy[0]), .done(dn[0]));
  shift_add_multiplier #(.WIDTH(8)) u8 (
    .clock(clock), .reset(reset), .start(st[1]), .signed_mode(sm[1]),
    .M(mv[1][7:0]), .Qin(qv[1][7:0]), .AQ(aq8), .ready(rdy[1]), .done(dn[1]));
  shift_add_multiplier #(.WIDTH(16)) u16 (
    .clock(clock), .reset(reset), .start(st[2]), .signed_mode(sm[2]),
    .M(mv[2][15:0]), .Qin(qv[2][15:0]), .AQ(aq16), .ready(rdy[2]), .done(dn[2]));

  assign aq_a[0] = {24'd0, aq4};
  assign aq_a[1] = {16'd0, aq8};
  assign aq_a[2] = aq16;

  function automatic logic [31:0] prod(input int w, input bit s,
                                       input logic [31:0] m, input logic [31:0] q);
    longint mask, mm, qq, p;
    mask = (longint'(1) << w) - 1;
    mm = longint'(m) & mask;
    qq = longint'(q) & mask;
    if (s && mm >= (longint'(1) << (w - 1))) mm = mm - (longint'(1) << w);
    if (s && qq >= (longint'(1) << (w - 1))) qq = qq - (longint'(1) << w);
    p = mm * qq;
    return 32'(p & ((longint'(1) << (2 * w)) - 1));
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clock or posedge reset) begin
    for (int k = 0; k < 3; k++) begin
      if (reset) begin
        idle_m[k]  <= 1'b1;
        valid_m[k] <= 1'b1;
        cnt_m[k]   <= 0;
        exp_m[k]   <= '0;
      end else if (idle_m[k] && st[k]) begin
        idle_m[k]  <= 1'b0;
        valid_m[k] <= 1'b0;
        cnt_m[k]   <= 0;
        exp_m[k]   <= prod(WD[k], sm[k], mv[k], qv[k]);
      end else if (!idle_m[k]) begin
        cnt_m[k] <= cnt_m[k] + 1;
        if (cnt_m[k] + 1 == WD[k] + 1) valid_m[k] <= 1'b1;
        if (cnt_m[k] + 1 == WD[k] + 2) idle_m[k]  <= 1'b1;
      end
    end
  end

  always @(negedge clock) begin
    for (int k = 0; k < 3; k++) begin
      check($sformatf("ready w%0d", WD[k]), 32'(rdy[k]), 32'(idle_m[k]));
      check($sformatf("done w%0d", WD[k]), 32'(dn[k]),
            32'(!idle_m[k] && cnt_m[k] == WD[k] + 1));
      if (valid_m[k]) check($sformatf("AQ w%0d", WD[k]), aq_a[k], exp_m[k]);
    end
  end

  // Operands and mode are scrambled after the accepting edge; the result must not change.
  task automatic op(input int k, input bit s, input logic [31:0] m, input logic [31:0] q);
    @(posedge clock); #1;
    st[k] = 1'b1; sm[k] = s; mv[k] = m; qv[k] = q;
    @(posedge clock); #1;
    st[k] = 1'b0; sm[k] = ~s; mv[k] = ~m; qv[k] = ~q;
    repeat (WD[k] + 2) @(posedge clock);
    #1;
  endtask

  task automatic op_lit(input bit s, input logic [31:0] m, input logic [31:0] q,
                        input logic [31:0] lit, input string name);
    op(0, s, m, q);
    check({"dut ", name}, aq_a[0], lit);
    check({"model ", name}, exp_m[0], lit);
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      mv[k] = '0;
      qv[k] = '0;
    end
    #3;
    check("reset AQ", aq_a[0], 32'h0);
    check("reset ready", 32'(rdy[0]), 32'h1);
    check("reset done", 32'(dn[0]), 32'h0);
    #9 reset = 1'b0;

    op_lit(1'b0, 32'd5,  32'd7,  32'h23, "5x7");
    op_lit(1'b0, 32'd15, 32'd15, 32'hE1, "15x15");
    op_lit(1'b1, 32'd13, 32'd5,  32'hF1, "-3x5");
    op_lit(1'b1, 32'd8,  32'd8,  32'h40, "-8x-8");
    op_lit(1'b1, 32'd7,  32'd15, 32'hF9, "7x-1");
    op_lit(1'b0, 32'd0,  32'd0,  32'h00, "0x0");

    // start held high: second op begins on the first IDLE edge with the changed operands
    @(posedge clock); #1;
    st[0] = 1'b1; sm[0] = 1'b0; mv[0] = 32'd3; qv[0] = 32'd5;
    @(posedge clock); #1;
    mv[0] = 32'd2; qv[0] = 32'd2;
    repeat (5) @(posedge clock);
    @(negedge clock);
    check("held first AQ", aq_a[0], 32'h0F);
    check("held first done", 32'(dn[0]), 32'h1);
    @(posedge clock);
    @(posedge clock); #1;
    st[0] = 1'b0;
    repeat (5) @(posedge clock);
    @(negedge clock);
    check("held second AQ", aq_a[0], 32'h04);
    check("held second done", 32'(dn[0]), 32'h1);

    // asynchronous reset in the third BUSY cycle
    @(posedge clock); #1;
    st[0] = 1'b1; sm[0] = 1'b0; mv[0] = 32'd15; qv[0] = 32'd15;
    @(posedge clock); #1;
    st[0] = 1'b0;
    @(posedge clock);
    @(posedge clock);
    #2 reset = 1'b1;
    #1;
    check("abort AQ", aq_a[0], 32'h0);
    check("abort ready", 32'(rdy[0]), 32'h1);
    check("abort done", 32'(dn[0]), 32'h0);
    #1 reset = 1'b0;
    repeat (10) @(posedge clock);
    #1;

    fork
      begin
        for (int s = 0; s < 2; s++)
          for (int m = 0; m < 16; m++)
            for (int q = 0; q < 16; q++)
              op(0, 1'(s), 32'(m), 32'(q));
      end
      begin
        op(1, 1'b1, 32'd128, 32'd128);
        check("w8 -128x-128", aq_a[1], 32'h4000);
        op(1, 1'b0, 32'd255, 32'd255);
        check("w8 255x255", aq_a[1], 32'hFE01);
        repeat (60) op(1, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 255)),
                       32'($urandom_range(0, 255)));
      end
      begin
        op(2, 1'b1, 32'h8000, 32'h8000);
        check("w16 min x min", aq_a[2], 32'h4000_0000);
        op(2, 1'b0, 32'hFFFF, 32'hFFFF);
        check("w16 max x max", aq_a[2], 32'hFFFE_0001);
        op(2, 1'b1, 32'hFFFF, 32'h7FFF);
        check("w16 -1 x max", aq_a[2], 32'hFFFF_8001);
        repeat (40) op(2, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 65535)),
                       32'($urandom_range(0, 65535)));
      end
    join

    repeat (3) @(posedge clock);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
